// File: rtl/mem_bus_responder.sv
// Byte-wide memory bus responder: RAM, UART-style RX/TX FIFOs, cycle counter and stop port.
// Optional cycle counter/snapshot enabled by defining CYCLE_COUNTER_EN.
module mem_bus_responder #(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned RX_DEPTH   = 8,
   parameter int unsigned TX_DEPTH   = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] bus_a,
   input  logic        bus_wr,
   input  logic [7:0]  bus_wdata,
   output logic [7:0]  bus_rdata,
   output logic        rdy_out,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        halt_o
);

   localparam int unsigned RAM_BYTES = 1 << ADDR_WIDTH;
   localparam int unsigned RX_AW     = $clog2(RX_DEPTH);
   localparam int unsigned RX_CW     = RX_AW + 1;
   localparam int unsigned TX_AW     = $clog2(TX_DEPTH);
   localparam int unsigned TX_CW     = TX_AW + 1;

   localparam logic [15:0] OFF_UART = 16'h0000;
   localparam logic [15:0] OFF_CNT0 = 16'h0004;
`ifdef CYCLE_COUNTER_EN
   localparam logic [15:0] OFF_CNT1 = 16'h0005;
   localparam logic [15:0] OFF_CNT2 = 16'h0006;
   localparam logic [15:0] OFF_CNT3 = 16'h0007;
`endif

   logic [7:0]            ram [RAM_BYTES];
   logic [7:0]            rx_mem [RX_DEPTH];
   logic [7:0]            tx_mem [TX_DEPTH];
   logic [RX_AW-1:0]      rx_wr_ptr, rx_rd_ptr;
   logic [TX_AW-1:0]      tx_wr_ptr, tx_rd_ptr;
   logic [RX_CW-1:0]      rx_count;
   logic [TX_CW-1:0]      tx_count;
   logic                  io_sel;
   logic [15:0]           io_off;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  rx_full, tx_full;
   logic                  rd_acc, wr_acc, io_wr, stop_wr;
   logic                  rx_push, rx_pop, tx_push, tx_pop;
   logic [7:0]            tx_push_data;
   logic [7:0]            rdata_c;
   logic                  unused_bus_a;

`ifdef CYCLE_COUNTER_EN
   logic [31:0]           cycle_cnt;
   logic [31:0]           snap;
`endif

   assign io_sel       = (bus_a[17:16] == 2'b11);
   assign io_off       = bus_a[15:0];
   assign ram_addr     = bus_a[ADDR_WIDTH-1:0];
   assign unused_bus_a = ^bus_a[31:18];

   assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
   assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
   assign rx_ready = rst_in & ~rx_full;
   assign rdy_out  = rst_in & ~tx_full;
   assign tx_valid = (tx_count != '0);
   assign tx_data  = tx_mem[tx_rd_ptr];

   // A bus cycle only takes effect while rdy_out is high.
   assign rd_acc  = rdy_out & ~bus_wr;
   assign wr_acc  = rdy_out & bus_wr;
   assign io_wr   = wr_acc & io_sel & ~halt_o;
   assign stop_wr = io_wr & (io_off == OFF_CNT0);

   assign rx_push      = rx_valid & rx_ready;
   assign rx_pop       = rd_acc & io_sel & (io_off == OFF_UART) & (rx_count != '0);
   assign tx_pop       = tx_valid & tx_ready;
   assign tx_push      = stop_wr | (io_wr & (io_off == OFF_UART) & (bus_wdata != 8'h00));
   assign tx_push_data = stop_wr ? 8'h00 : bus_wdata;

   // Read data selected for the next registered response.
   always_comb begin
      rdata_c = 8'h00;
      if (!io_sel) begin
         rdata_c = ram[ram_addr];
      end else begin
         case (io_off)
            OFF_UART: if (rx_count != '0) rdata_c = rx_mem[rx_rd_ptr];
`ifdef CYCLE_COUNTER_EN
            OFF_CNT0: rdata_c = cycle_cnt[7:0];
            OFF_CNT1: rdata_c = snap[15:8];
            OFF_CNT2: rdata_c = snap[23:16];
            OFF_CNT3: rdata_c = snap[31:24];
`endif
            default:  rdata_c = 8'h00;
         endcase
      end
   end

   // RAM is deliberately left out of reset.
   always_ff @(posedge clk_in) begin
      if (wr_acc && !io_sel) ram[ram_addr] <= bus_wdata;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         bus_rdata <= 8'h00;
         halt_o    <= 1'b0;
      end else begin
         if (rd_acc)  bus_rdata <= rdata_c;
         if (stop_wr) halt_o    <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
      if (tx_push) tx_mem[tx_wr_ptr] <= tx_push_data;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
         rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
         tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
      end
   end

`ifdef CYCLE_COUNTER_EN
   // Free-running counter; a read of the low byte latches the whole value.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         cycle_cnt <= '0;
         snap      <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (rd_acc && io_sel && (io_off == OFF_CNT0)) snap <= cycle_cnt;
      end
   end
`endif

endmodule
